// File: rtl/bp_cce_sharers_iter.sv
// Walks a captured sharers-hit vector one set bit at a time, presenting each
// LCE index (lowest first) to the CCE pipeline under a valid/yumi handshake.
module bp_cce_sharers_iter #(
    parameter int unsigned num_lce_p = 8,
    parameter int unsigned width_p   = 64,
    localparam int unsigned lg_num_lce_lp = (num_lce_p > 1) ? $clog2(num_lce_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  logic [num_lce_p-1:0]     hits_i,
    input  logic                     skip_v_i,
    input  logic [lg_num_lce_lp-1:0] skip_lce_i,
    input  logic                     abort_i,
    output logic                     idx_v_o,
    output logic [width_p-1:0]       idx_o,
    input  logic                     idx_yumi_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [lg_num_lce_lp:0]   count_o
);

    localparam int unsigned count_w = lg_num_lce_lp + 1;

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_scan = 2'd1,
        e_done = 2'd2
    } state_e;

    state_e                   state_r, state_n;
    logic [num_lce_p-1:0]     pending_r, pending_n;
    logic [count_w-1:0]       count_r, count_n;

    logic [num_lce_p-1:0]     skip_mask, captured, clr_mask, pending_after;
    logic [lg_num_lce_lp-1:0] enc;

    // Capture mask; an out-of-range skip_lce_i matches no bit and excludes nothing.
    always_comb begin
        skip_mask = '0;
        clr_mask  = '0;
        enc       = '0;
        for (int i = num_lce_p - 1; i >= 0; i--) begin
            if (pending_r[i]) enc = lg_num_lce_lp'(i);
        end
        for (int i = 0; i < num_lce_p; i++) begin
            skip_mask[i] = skip_v_i && (skip_lce_i == lg_num_lce_lp'(i));
            clr_mask[i]  = (enc == lg_num_lce_lp'(i));
        end
        captured      = hits_i & ~skip_mask;
        pending_after = pending_r & ~clr_mask;
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= e_idle;
        else         state_r <= state_n;
    end

    // Next-state logic; abort dominates start and yumi
    always_comb begin
        state_n = state_r;
        if (abort_i) begin
            state_n = e_idle;
        end else begin
            unique case (state_r)
                e_idle: if (start_i) state_n = (captured != '0) ? e_scan : e_done;
                e_scan: if (idx_yumi_i && (pending_after == '0)) state_n = e_done;
                e_done: state_n = e_idle;
                default: state_n = e_idle;
            endcase
        end
    end

    // Pending vector and consumed-index counter
    always_comb begin
        pending_n = pending_r;
        count_n   = count_r;
        if (abort_i) begin
            pending_n = '0;
        end else if ((state_r == e_idle) && start_i) begin
            pending_n = captured;
            count_n   = '0;
        end else if ((state_r == e_scan) && idx_yumi_i) begin
            pending_n = pending_after;
            count_n   = count_r + count_w'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending_r <= '0;
            count_r   <= '0;
        end else begin
            pending_r <= pending_n;
            count_r   <= count_n;
        end
    end

    // Outputs depend only on registered state
    always_comb begin
        busy_o  = 1'b0;
        done_o  = 1'b0;
        idx_v_o = 1'b0;
        idx_o   = width_p'(enc);
        count_o = count_r;
        busy_o  = (state_r != e_idle);
        done_o  = (state_r == e_done);
        idx_v_o = (state_r == e_scan) && (pending_r != '0);
    end

endmodule

// File: tb/tb_bp_cce_sharers_iter.sv
// Randomized and directed bench for bp_cce_sharers_iter against a queue-based
// model of the expected LCE index sequence.
module tb_bp_cce_sharers_iter;

    localparam int unsigned N  = 8;
    localparam int unsigned LG = 3;
    localparam int unsigned W  = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [N-1:0]  hits;
    logic          skip_v;
    logic [LG-1:0] skip_lce;
    logic          abort;
    logic          idx_v;
    logic [W-1:0]  idx;
    logic          idx_yumi;
    logic          busy;
    logic          done;
    logic [LG:0]   count;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    bp_cce_sharers_iter #(.num_lce_p(N), .width_p(W)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start),
        .hits_i     (hits),
        .skip_v_i   (skip_v),
        .skip_lce_i (skip_lce),
        .abort_i    (abort),
        .idx_v_o    (idx_v),
        .idx_o      (idx),
        .idx_yumi_i (idx_yumi),
        .busy_o     (busy),
        .done_o     (done),
        .count_o    (count)
    );

    always #5 clk = ~clk;

    // Consumer protocol: a yumi is only legal while an index is offered
    always @(posedge clk) begin
        if (!reset && idx_yumi && !idx_v) begin
            errors++;
            $display("FAIL yumi_without_valid at %0t", $time);
        end
    end

    // Expected order: every set, non-skipped bit, lowest LCE first
    function automatic void model_build(input logic [N-1:0] h, input logic sv, input int sl);
        exp_q.delete();
        for (int i = 0; i < int'(N); i++) begin
            if (h[i] && !(sv && sl == i)) exp_q.push_back(i);
        end
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; hits = '0; skip_v = 1'b0; skip_lce = '0;
        abort = 1'b0; idx_yumi = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (idx_v !== 1'b0) begin errors++; $display("FAIL reset_idx_v got=%b exp=0", idx_v); end
        checks++; if (idx !== '0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", idx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    endtask

    // Directed table (yumi held high) followed by random vectors with random yumi
    task automatic test_scan_patterns();
        logic [N-1:0] t_hits [4] = '{8'b1010_0110, 8'b0000_1001, 8'h00, 8'h08};
        logic         t_sv   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int           t_sl   [4] = '{0, 3, 0, 3};
        for (int t = 0; t < 24; t++) begin
            logic [N-1:0] h;
            logic sv;
            int sl, cnt, budget, pct;
            if (t < 4) begin
                h = t_hits[t]; sv = t_sv[t]; sl = t_sl[t]; pct = 100;
            end else begin
                h = N'($urandom); sv = 1'($urandom); sl = int'($urandom_range(0, N - 1)); pct = 60;
            end
            model_build(h, sv, sl);
            start = 1'b1; hits = h; skip_v = sv; skip_lce = LG'(sl);
            @(negedge clk);
            start = 1'b0; hits = $urandom;
            cnt = 0; budget = 200;
            while (exp_q.size() > 0 && budget > 0) begin
                logic y;
                checks++; if (idx_v !== 1'b1) begin errors++; $display("FAIL scan_idx_v t=%0d got=%b exp=1", t, idx_v); end
                checks++; if (idx !== W'(exp_q[0])) begin errors++; $display("FAIL scan_idx t=%0d got=%0d exp=%0d", t, idx, exp_q[0]); end
                checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL scan_flags t=%0d done=%b busy=%b exp done=0 busy=1", t, done, busy); end
                checks++; if (count !== (LG+1)'(cnt)) begin errors++; $display("FAIL scan_count t=%0d got=%0d exp=%0d", t, count, cnt); end
                y = ($urandom_range(1, 100) <= pct);
                idx_yumi = y;
                @(negedge clk);
                if (y) begin void'(exp_q.pop_front()); cnt++; end
                budget--;
            end
            idx_yumi = 1'b0;
            checks++; if (budget == 0) begin errors++; $display("FAIL scan_timeout t=%0d remaining=%0d exp=0", t, exp_q.size()); end
            checks++; if (done !== 1'b1 || idx_v !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL done_cycle t=%0d done=%b idx_v=%b busy=%b exp 1/0/1", t, done, idx_v, busy); end
            checks++; if (count !== (LG+1)'(cnt)) begin errors++; $display("FAIL done_count t=%0d got=%0d exp=%0d", t, count, cnt); end
            @(negedge clk);
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL after_done t=%0d done=%b busy=%b exp 0/0", t, done, busy); end
            checks++; if (count !== (LG+1)'(cnt)) begin errors++; $display("FAIL hold_count t=%0d got=%0d exp=%0d", t, count, cnt); end
        end
    endtask

    // Alternating yumi with a stray start mid-scan that must be ignored
    task automatic test_stall();
        int cyc = 0;
        int cnt = 0;
        model_build(8'hFF, 1'b0, 0);
        start = 1'b1; hits = 8'hFF; skip_v = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (exp_q.size() > 0 && cyc < 40) begin
            checks++; if (idx_v !== 1'b1 || idx !== W'(exp_q[0])) begin
                errors++; $display("FAIL stall_idx cyc=%0d got=%0d v=%b exp=%0d", cyc, idx, idx_v, exp_q[0]); end
            idx_yumi = (cyc % 2 == 0);
            start = (cyc == 3); hits = 8'h00;
            @(negedge clk);
            if (cyc % 2 == 0) begin void'(exp_q.pop_front()); cnt++; end
            cyc++;
        end
        idx_yumi = 1'b0; start = 1'b0;
        checks++; if (done !== 1'b1 || count !== (LG+1)'(cnt) || cnt != 8) begin
            errors++; $display("FAIL stall_done done=%b count=%0d consumed=%0d exp 1/8/8", done, count, cnt); end
        @(negedge clk);
    endtask

    task automatic test_abort_restart();
        start = 1'b1; hits = 8'hF0; skip_v = 1'b0;
        @(negedge clk);
        start = 1'b0; idx_yumi = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (idx !== W'(6) || count !== 4'd2) begin errors++; $display("FAIL abort_pre idx=%0d count=%0d exp 6/2", idx, count); end
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0; idx_yumi = 1'b0;
        checks++; if (busy !== 1'b0 || idx_v !== 1'b0 || done !== 1'b0 || count !== 4'd2) begin
            errors++; $display("FAIL abort_idle busy=%b idx_v=%b done=%b count=%0d exp 0/0/0/2", busy, idx_v, done, count); end
        start = 1'b1; hits = 8'h01;
        @(negedge clk);
        start = 1'b0;
        checks++; if (idx_v !== 1'b1 || idx !== '0 || count !== '0) begin
            errors++; $display("FAIL restart_idx v=%b idx=%0d count=%0d exp 1/0/0", idx_v, idx, count); end
        idx_yumi = 1'b1;
        @(negedge clk);
        idx_yumi = 1'b0;
        checks++; if (done !== 1'b1 || count !== 4'd1) begin errors++; $display("FAIL restart_done done=%b count=%0d exp 1/1", done, count); end
        @(negedge clk);
        start = 1'b1; abort = 1'b1; hits = 8'h0F;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || count !== 4'd1) begin
            errors++; $display("FAIL abort_beats_start busy=%b done=%b count=%0d exp 0/0/1", busy, done, count); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; hits = 8'hFF;
        @(negedge clk);
        start = 1'b0; idx_yumi = 1'b1;
        @(negedge clk);
        reset = 1'b1; abort = 1'b1; start = 1'b1;
        @(negedge clk);
        reset = 1'b0; abort = 1'b0; start = 1'b0; idx_yumi = 1'b0;
        checks++; if (idx_v !== 1'b0 || idx !== '0 || busy !== 1'b0 || done !== 1'b0 || count !== '0) begin
            errors++; $display("FAIL reset_mid v=%b idx=%0d busy=%b done=%b count=%0d exp all 0", idx_v, idx, busy, done, count); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid_after done=%b busy=%b exp 0/0", done, busy); end
    endtask

    initial begin
        test_reset();
        test_scan_patterns();
        test_stall();
        test_abort_restart();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_cce_sharers_iter.md
# bp_cce_sharers_iter

Sequencer that walks a captured sharers-hit vector one set bit at a time and presents each LCE index to the CCE instruction pipeline as a GPR-width source operand. It sits beside the CCE source-select datapath and supplies the rX index that sharers-vector operands (hit/way/state lookups) need, so microcode can loop over sharers without a software bit-scan. Handshake is valid/yumi toward the consumer, with start/abort control from the CCE decoder.

## Interface
- num_lce_p, 8, number of LCEs; width of the hit vector; must be ≥ 1
- width_p, 64, output index width (CCE GPR width); must be ≥ lg_num_lce_lp
- lg_num_lce_lp (local), `BSG_SAFE_CLOG2(num_lce_p)`
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  capture hits_i and begin iteration (honoured only in IDLE)
- hits_i  in  num_lce_p  sharers-hit vector sampled on accepted start
- skip_v_i  in  1  exclude skip_lce_i from the captured vector
- skip_lce_i  in  lg_num_lce_lp  LCE to exclude (e.g. requesting LCE); sampled with start
- abort_i  in  1  terminate iteration, return to IDLE
- idx_v_o  out  1  idx_o holds a valid pending LCE index
- idx_o  out  width_p  lowest-numbered pending LCE, zero-extended
- idx_yumi_i  in  1  consumer takes idx_o this cycle; legal only while idx_v_o
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-cycle pulse: all captured indices consumed
- count_o  out  lg_num_lce_lp+1  number of indices consumed since last accepted start

## Operation
- States: IDLE, SCAN, DONE. Registers: state, pending[num_lce_p], count.
- IDLE: busy_o=0, idx_v_o=0. On start_i & ~abort_i: pending ← hits_i & ~(skip_v_i ? onehot(skip_lce_i) : 0); count ← 0; go SCAN if captured vector ≠ 0, else DONE.
- SCAN: idx_v_o = |pending (always 1 in SCAN); idx_o = priority-encode(pending), lowest index wins, upper bits zero. On idx_yumi_i: clear that bit, count ← count+1; if resulting pending = 0 go DONE, else stay.
- DONE: done_o=1 for exactly this cycle; idx_v_o=0; next state IDLE. count_o holds final value until next accepted start.
- abort_i: from any state, next state IDLE, pending ← 0; no done_o pulse; count_o retains value. abort_i has priority over start_i and idx_yumi_i in the same cycle.
- start_i outside IDLE is ignored (no recapture). skip_lce_i ≥ num_lce_p excludes nothing.
- idx_yumi_i without idx_v_o is ignored; bench asserts it never happens.
- count saturation impossible: max value num_lce_p fits lg_num_lce_lp+1 bits.

## Timing
- Reset: state=IDLE, pending=0, count=0; idx_v_o=0, idx_o=0, busy_o=0, done_o=0, count_o=0.
- Start accepted at edge N: idx_v_o=1 in cycle N+1 (non-empty) or done_o=1 in cycle N+1 (empty).
- idx_o/idx_v_o are combinational from registered pending only; no combinational path from any input to any output.
- Throughput: one index per cycle with idx_yumi_i held high; k set bits → done_o k cycles after first idx_v_o, i.e. N+1+k.
- Last yumi at edge M: done_o in cycle M+1, busy_o=0 and new start acceptable in cycle M+2.
- reset_i mid-iteration: returns to reset values next cycle, no done_o.

## Test plan
- num_lce_p=8, start with hits_i=8'b1010_0110, no skip, yumi held high → idx_o 1,2,5,7 on consecutive cycles, done_o on next cycle, count_o=4.
- hits_i=8'b0000_1001, skip_v_i=1, skip_lce_i=3 → single idx_o=0, then done_o, count_o=1.
- hits_i=0 (or only skipped bit set) → no idx_v_o, done_o in cycle after start, count_o=0.
- hits_i=8'hFF, yumi toggling 1,0,1,0 → idx_o stalls on unacked cycles, sequence 0..7 unchanged, done_o after 8th yumi; start_i pulsed mid-scan has no effect.
- hits_i=8'hF0, abort_i after two yumis → IDLE next cycle, no done_o, count_o=2; immediate restart with 8'h01 yields idx_o=0, count_o=1.
- reset_i asserted during SCAN with abort_i and start_i also high → all outputs at reset values next cycle.
